// File: rtl/avsdpll_ctrl_pkg.sv
// Shared widths, state encodings and helpers for the AVS DPLL lock controller.
package avsdpll_ctrl_pkg;

  localparam int unsigned FB_W = 8;
  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] ST_OFF       = 3'd0;
  localparam logic [ST_W-1:0] ST_VCO_START = 3'd1;
  localparam logic [ST_W-1:0] ST_ACQUIRE   = 3'd2;
  localparam logic [ST_W-1:0] ST_LOCK      = 3'd3;
  localparam logic [ST_W-1:0] ST_FAULT     = 3'd4;

  // Feedback edge counter step that sticks at all-ones instead of wrapping.
  function automatic logic [FB_W-1:0] fb_sat_inc(input logic [FB_W-1:0] v,
                                                  input logic            inc);
    return (inc && (v != '1)) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/avsdpll_edge_sync.sv
// Two-flop synchronizer plus delay flop; emits a one-CLK pulse per rising edge of i_async.
module avsdpll_edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_pulse
);

  logic r_s1;
  logic r_s2;
  logic r_dly;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_dly <= 1'b0;
    end else begin
      r_s1  <= i_async;
      r_s2  <= r_s1;
      r_dly <= r_s2;
    end
  end

  // Pulse is consumed by the third CLK edge after the asynchronous edge.
  assign o_pulse = r_s2 & ~r_dly;

endmodule

// File: rtl/avsdpll_ctrl.sv
// AVS DPLL enable sequencer: VCO/charge-pump power-up, REF-window frequency check, lock/fault.
module avsdpll_ctrl
  import avsdpll_ctrl_pkg::*;
#(
  parameter int WIN     = 16,
  parameter int TOL     = 1,
  parameter int LOCK_N  = 4,
  parameter int SETTLE  = 64,
  parameter int ACQ_MAX = 32
) (
  input  logic            CLK,
  input  logic            RSTb,
  input  logic            EN,
  input  logic            REF,
  input  logic            PLL_FB,
  output logic            ENb_VCO,
  output logic            ENb_CP,
  output logic            LOCKED,
  output logic            FAULT,
  output logic [ST_W-1:0] STATE,
  output logic [FB_W-1:0] FB_COUNT
);

  localparam logic [5:0]      C_WIN_LAST    = 6'(WIN - 1);
  localparam logic [FB_W-1:0] C_LO          = FB_W'((WIN > TOL) ? (WIN - TOL) : 0);
  localparam logic [FB_W-1:0] C_HI          = FB_W'(WIN + TOL);
  localparam logic [15:0]     C_SETTLE_LAST = 16'(SETTLE - 1);
  localparam logic [15:0]     C_ACQ_LAST    = 16'(ACQ_MAX - 1);
  localparam logic [7:0]      C_LOCK_LAST   = 8'(LOCK_N - 1);

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_state_nxt;
  logic [15:0]     r_settle;
  logic [5:0]      r_win;
  logic [FB_W-1:0] r_fb;
  logic [7:0]      r_good;
  logic            r_bad;
  logic [15:0]     r_acq;
  logic [FB_W-1:0] r_fb_count;
  logic            r_enb_vco;
  logic            r_enb_cp;
  logic            r_locked;
  logic            r_fault;

  logic            w_ref_pls;
  logic            w_fb_pls;
  logic            w_active;
  logic            w_active_nxt;
  logic            w_enter_acq;
  logic            w_close;
  logic [FB_W-1:0] w_fb_sat;
  logic            w_good;

  avsdpll_edge_sync u_ref_sync (
    .i_clk   (CLK),
    .i_rst_n (RSTb),
    .i_async (REF),
    .o_pulse (w_ref_pls)
  );

  avsdpll_edge_sync u_fb_sync (
    .i_clk   (CLK),
    .i_rst_n (RSTb),
    .i_async (PLL_FB),
    .o_pulse (w_fb_pls)
  );

  assign w_active     = (r_state == ST_ACQUIRE) || (r_state == ST_LOCK);
  assign w_active_nxt = (w_state_nxt == ST_ACQUIRE) || (w_state_nxt == ST_LOCK);
  assign w_enter_acq  = (w_state_nxt == ST_ACQUIRE) && (r_state != ST_ACQUIRE);
  assign w_close      = w_active && w_ref_pls && (r_win == C_WIN_LAST);
  // A feedback pulse landing on the closing REF pulse belongs to the closing window.
  assign w_fb_sat     = fb_sat_inc(r_fb, w_fb_pls);
  assign w_good       = (w_fb_sat >= C_LO) && (w_fb_sat <= C_HI);

  always_comb begin
    w_state_nxt = r_state;
    if (!EN) begin
      w_state_nxt = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF:       w_state_nxt = ST_VCO_START;
        ST_VCO_START: if (r_settle == C_SETTLE_LAST) w_state_nxt = ST_ACQUIRE;
        ST_ACQUIRE: begin
          if (w_close) begin
            if (w_good && (r_good == C_LOCK_LAST)) w_state_nxt = ST_LOCK;
            else if (r_acq == C_ACQ_LAST)          w_state_nxt = ST_FAULT;
          end
        end
        ST_LOCK:      if (w_close && !w_good && r_bad) w_state_nxt = ST_ACQUIRE;
        ST_FAULT:     w_state_nxt = ST_FAULT;
        default:      w_state_nxt = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_state  <= ST_OFF;
      r_settle <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_VCO_START) && (w_state_nxt == ST_VCO_START))
        r_settle <= r_settle + 1'b1;
      else
        r_settle <= '0;
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_win      <= '0;
      r_fb       <= '0;
      r_good     <= '0;
      r_bad      <= 1'b0;
      r_acq      <= '0;
      r_fb_count <= '0;
    end else if (w_enter_acq || !w_active_nxt) begin
      r_win  <= '0;
      r_fb   <= '0;
      r_good <= '0;
      r_bad  <= 1'b0;
      r_acq  <= '0;
    end else begin
      r_fb  <= w_close ? '0 : w_fb_sat;
      r_win <= w_close ? '0 : (w_ref_pls ? r_win + 1'b1 : r_win);
      if (w_close) begin
        r_fb_count <= w_fb_sat;
        if (r_state == ST_ACQUIRE) begin
          r_acq  <= r_acq + 1'b1;
          r_good <= w_good ? r_good + 1'b1 : '0;
          r_bad  <= 1'b0;
        end else begin
          r_bad  <= !w_good;
        end
      end
    end
  end

  // Outputs are registered from the next state so they change with STATE.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_enb_vco <= 1'b1;
      r_enb_cp  <= 1'b1;
      r_locked  <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_enb_vco <= !((w_state_nxt == ST_VCO_START) || w_active_nxt);
      r_enb_cp  <= !w_active_nxt;
      r_locked  <= (w_state_nxt == ST_LOCK);
      r_fault   <= (w_state_nxt == ST_FAULT);
    end
  end

  assign STATE    = r_state;
  assign ENb_VCO  = r_enb_vco;
  assign ENb_CP   = r_enb_cp;
  assign LOCKED   = r_locked;
  assign FAULT    = r_fault;
  assign FB_COUNT = r_fb_count;

endmodule

// File: tb/tb_avsdpll_ctrl.sv
// Directed bench for avsdpll_ctrl: power-up sequencing, lock, loss of lock, fault and async reset.
module tb_avsdpll_ctrl;
  import avsdpll_ctrl_pkg::*;

  logic            CLK = 1'b0;
  logic            RSTb;
  logic            EN;
  logic            REF;
  logic            PLL_FB;
  logic            ENb_VCO;
  logic            ENb_CP;
  logic            LOCKED;
  logic            FAULT;
  logic [ST_W-1:0] STATE;
  logic [FB_W-1:0] FB_COUNT;

  int n_checks = 0;
  int n_errors = 0;

  always #10 CLK = ~CLK;

  avsdpll_ctrl #(
    .WIN     (16),
    .TOL     (1),
    .LOCK_N  (4),
    .SETTLE  (64),
    .ACQ_MAX (32)
  ) dut (
    .CLK      (CLK),
    .RSTb     (RSTb),
    .EN       (EN),
    .REF      (REF),
    .PLL_FB   (PLL_FB),
    .ENb_VCO  (ENb_VCO),
    .ENb_CP   (ENb_CP),
    .LOCKED   (LOCKED),
    .FAULT    (FAULT),
    .STATE    (STATE),
    .FB_COUNT (FB_COUNT)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // One 1 us REF period (50 CLK): fb_n feedback edges early in the period, REF rises at
  // cycle 25; with coin set an extra feedback edge rises together with REF.
  task automatic ref_period(input int fb_n, input bit coin);
    for (int c = 0; c < 50; c++) begin
      @(negedge CLK);
      REF    = (c >= 25) && (c < 49);
      PLL_FB = 1'b0;
      for (int e = 0; e < fb_n; e++)
        if ((c >= 5 + 10 * e) && (c < 9 + 10 * e)) PLL_FB = 1'b1;
      if (coin && (c >= 25) && (c < 29)) PLL_FB = 1'b1;
    end
  endtask

  // Sixteen REF periods carrying n feedback edges in total (0..32).
  task automatic run_window(input int n, input bit coin_last);
    int n2;
    int n0;
    int fb_n;
    n2 = (n > 16) ? n - 16 : 0;
    n0 = (n < 16) ? 16 - n : 0;
    for (int p = 0; p < 16; p++) begin
      fb_n = 1;
      if (p < n2) fb_n = 2;
      if (p < n0) fb_n = 0;
      if (coin_last && (p == 15)) ref_period(fb_n - 1, 1'b1);
      else                        ref_period(fb_n, 1'b0);
    end
  endtask

  initial begin
    RSTb   = 1'b0;
    EN     = 1'b0;
    REF    = 1'b0;
    PLL_FB = 1'b0;
    #35;
    chk("rst_state",   STATE,    0);
    chk("rst_enb_vco", ENb_VCO,  1);
    chk("rst_enb_cp",  ENb_CP,   1);
    chk("rst_locked",  LOCKED,   0);
    chk("rst_fault",   FAULT,    0);
    chk("rst_fbcnt",   FB_COUNT, 0);
    @(negedge CLK);
    RSTb = 1'b1;
    step(3);
    chk("off_hold", STATE, 0);

    // Power-up and lock with matched REF / feedback
    EN = 1'b1;
    step(1);
    chk("vco_state",   STATE,   1);
    chk("vco_enb_vco", ENb_VCO, 0);
    chk("vco_enb_cp",  ENb_CP,  1);
    step(63);
    chk("settle_63_cp", ENb_CP, 1);
    chk("settle_63_st", STATE,  1);
    step(1);
    chk("settle_64_cp", ENb_CP, 0);
    chk("settle_64_st", STATE,  2);
    repeat (3) run_window(16, 1'b0);
    chk("w3_locked", LOCKED,   0);
    chk("w3_state",  STATE,    2);
    chk("w3_fbcnt",  FB_COUNT, 16);
    run_window(16, 1'b0);
    chk("w4_locked", LOCKED,   1);
    chk("w4_state",  STATE,    3);
    chk("w4_fbcnt",  FB_COUNT, 16);

    // Feedback runs fast (20 edges per window): drop only after the second bad window
    run_window(20, 1'b0);
    chk("bad1_fbcnt",  FB_COUNT, 20);
    chk("bad1_locked", LOCKED,   1);
    chk("bad1_state",  STATE,    3);
    run_window(20, 1'b0);
    chk("bad2_fbcnt",  FB_COUNT, 20);
    chk("bad2_locked", LOCKED,   0);
    chk("bad2_state",  STATE,    2);

    // Tolerance edges: 17 and 15 good, 18 bad and restarts the good run
    run_window(17, 1'b0);
    chk("tol17_fbcnt", FB_COUNT, 17);
    run_window(15, 1'b0);
    chk("tol15_fbcnt", FB_COUNT, 15);
    run_window(18, 1'b0);
    chk("tol18_fbcnt", FB_COUNT, 18);
    chk("tol18_state", STATE,    2);
    repeat (3) run_window(16, 1'b0);
    chk("run3_locked", LOCKED, 0);
    chk("run3_state",  STATE,  2);
    run_window(16, 1'b0);
    chk("run4_locked", LOCKED, 1);
    chk("run4_state",  STATE,  3);

    // Bad windows separated by a good one never drop lock
    run_window(20, 1'b0);
    run_window(16, 1'b0);
    run_window(20, 1'b0);
    chk("sep_bad_locked", LOCKED, 1);
    chk("sep_bad_state",  STATE,  3);

    // Feedback edge coincident with the closing REF edge
    run_window(16, 1'b1);
    chk("coin_fbcnt",  FB_COUNT, 16);
    chk("coin_locked", LOCKED,   1);
    run_window(16, 1'b0);
    chk("after_coin_fbcnt", FB_COUNT, 16);

    // Asynchronous reset while locked, then full relock
    @(negedge CLK);
    #3 RSTb = 1'b0;
    #2;
    chk("arst_state",   STATE,    0);
    chk("arst_enb_vco", ENb_VCO,  1);
    chk("arst_enb_cp",  ENb_CP,   1);
    chk("arst_locked",  LOCKED,   0);
    chk("arst_fault",   FAULT,    0);
    chk("arst_fbcnt",   FB_COUNT, 0);
    step(2);
    RSTb = 1'b1;
    step(1);
    chk("rel_state",   STATE,   1);
    chk("rel_enb_vco", ENb_VCO, 0);
    step(64);
    chk("rel_acq_state", STATE,  2);
    chk("rel_acq_cp",    ENb_CP, 0);
    repeat (4) run_window(16, 1'b0);
    chk("relock_locked", LOCKED,   1);
    chk("relock_state",  STATE,    3);
    chk("relock_fbcnt",  FB_COUNT, 16);

    // EN low forces OFF; then dead feedback leads to FAULT after 32 windows
    EN = 1'b0;
    step(1);
    chk("dis_state",   STATE,   0);
    chk("dis_enb_vco", ENb_VCO, 1);
    chk("dis_enb_cp",  ENb_CP,  1);
    chk("dis_locked",  LOCKED,  0);
    EN = 1'b1;
    step(65);
    chk("f_acq_state", STATE, 2);
    repeat (31) run_window(0, 1'b0);
    chk("f31_state", STATE, 2);
    chk("f31_fault", FAULT, 0);
    run_window(0, 1'b0);
    chk("f32_state",   STATE,    4);
    chk("f32_fault",   FAULT,    1);
    chk("f32_enb_vco", ENb_VCO,  1);
    chk("f32_enb_cp",  ENb_CP,   1);
    chk("f32_locked",  LOCKED,   0);
    chk("f32_fbcnt",   FB_COUNT, 0);
    step(10);
    chk("f_hold", FAULT, 1);
    EN = 1'b0;
    step(1);
    chk("f_clr_state", STATE, 0);
    chk("f_clr_fault", FAULT, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/avsdpll_ctrl.md
AVSDPLL_CTRL -- requirements
Module: avsdpll_ctrl

Interface
REQ-001 SHALL have parameter WIN, default 16, meaning REF rising edges per measurement window (range 4..64).
REQ-002 SHALL have parameter TOL, default 1, meaning allowed |fb_count - WIN| for a good window.
REQ-003 SHALL have parameter LOCK_N, default 4, meaning consecutive good windows needed to declare lock.
REQ-004 SHALL have parameter SETTLE, default 64, meaning CLK cycles from VCO enable to charge-pump enable.
REQ-005 SHALL have parameter ACQ_MAX, default 32, meaning windows allowed in ACQUIRE before FAULT.
REQ-006 SHALL have port CLK input 1, free-running controller clock, at least 4x the REF and PLL_FB frequencies.
REQ-007 SHALL have port RSTb input 1; one clock; reset is asynchronous and active-low.
REQ-008 SHALL have port EN input 1, synchronous software enable for the PLL.
REQ-009 SHALL have port REF input 1, asynchronous PLL reference clock.
REQ-010 SHALL have port PLL_FB input 1, asynchronous PLL output after the external divide-by-N.
REQ-011 SHALL have port ENb_VCO output 1, active-low VCO enable.
REQ-012 SHALL have port ENb_CP output 1, active-low charge-pump enable.
REQ-013 SHALL have ports LOCKED output 1, FAULT output 1, STATE output 3, FB_COUNT output 8 (count of the last completed window).

Function
REQ-014 SHALL pass REF and PLL_FB each through a 2-flop synchronizer plus delay flop, giving a one-cycle rising-edge pulse 3 CLK cycles after the edge.
REQ-015 SHALL implement states OFF=0, VCO_START=1, ACQUIRE=2, LOCK=3, FAULT=4 on STATE.
REQ-016 SHALL hold OFF while EN=0 and move OFF->VCO_START on the first cycle EN=1.
REQ-017 SHALL drive ENb_VCO=0 in VCO_START, ACQUIRE and LOCK, and ENb_VCO=1 otherwise.
REQ-018 SHALL drive ENb_CP=0 only in ACQUIRE and LOCK.
REQ-019 SHALL leave VCO_START for ACQUIRE after exactly SETTLE CLK cycles.
REQ-020 SHALL clear the window, feedback and good/bad/acquire counters when entering ACQUIRE.
REQ-021 SHALL, in ACQUIRE and LOCK, count REF edge pulses 0..WIN-1, and close the window on the REF pulse at WIN-1.
REQ-022 SHALL count PLL_FB edge pulses in an 8-bit counter saturating at 255.
REQ-023 SHALL count a PLL_FB pulse that coincides with window close in the closing window; the next window SHALL start at 0.
REQ-024 SHALL load FB_COUNT with the count at window close, and mark the window good iff WIN-TOL <= count <= WIN+TOL.
REQ-025 SHALL move ACQUIRE->LOCK after LOCK_N consecutive good windows; a bad window SHALL reset the good-run count.
REQ-026 SHALL move ACQUIRE->FAULT when ACQ_MAX windows close without lock.
REQ-027 SHALL assert LOCKED=1 only in LOCK, registered, from the cycle after the closing window.
REQ-028 SHALL move LOCK->ACQUIRE after 2 consecutive bad windows; a single bad window SHALL not drop LOCKED.
REQ-029 SHALL assert FAULT=1 only in FAULT, and hold FAULT until EN=0.
REQ-030 SHALL, on EN=0 in any state, enter OFF on the next CLK edge with ENb_CP=ENb_VCO=1 and LOCKED=0.

Reset
REQ-031 SHALL, while RSTb=0, force STATE=OFF, ENb_VCO=1, ENb_CP=1, LOCKED=0, FAULT=0, FB_COUNT=0, and clear all counters and synchronizer flops.
REQ-032 SHALL, on reset release with EN=1, enter VCO_START one cycle after the first active edge.

Structure
REQ-033 SHALL place the state encoding, the FB counter width (8) and the state width (3) in package avsdpll_ctrl_pkg.
REQ-034 SHALL use one sub-module, avsdpll_edge_sync (synchronizer plus rising-edge pulse), instantiated once for REF and once for PLL_FB.

Verification
REQ-035 SHALL test: EN=1, REF=PLL_FB=1 MHz, CLK=50 MHz -> ENb_VCO low, then ENb_CP low 64 cycles later, LOCKED=1 after 4 windows, FB_COUNT=16.
REQ-036 SHALL test: lock reached, then PLL_FB=1.25 MHz -> FB_COUNT=20, LOCKED stays 1 after the 1st bad window and drops after the 2nd, STATE=2.
REQ-037 SHALL test: PLL_FB held at 0 -> FAULT=1 and STATE=4 after 32 windows with both ENb high; EN=0 -> STATE=0 and FAULT=0.
REQ-038 SHALL test: PLL_FB edges of 17, 15 and 18 per window -> 17 and 15 good, 18 bad, and the good-run count restarts.
REQ-039 SHALL test: PLL_FB edge pulse coinciding with window close -> counted in the closing window (FB_COUNT=16), next window starts at 0.
REQ-040 SHALL test: RSTb pulsed low in LOCK -> all outputs at reset values asynchronously, then a full relock sequence.
